// File: rtl/ras_checkpoint_manager.sv
// Purpose: sequences RAS push/pop from dispatch and keeps a ring of speculation checkpoints (sp/count snapshots).
// Latency: push/pop/alloc are combinational (0 cycles); the restore pulse follows a mispredict by one cycle.
// Backpressure: dispatch_stall during RESTORE, on a same-cycle mispredict, or when a checkpoint is needed and none is free.
//
// Ports: dispatch hints (dispatch_valid, branch, jump, jalr, jalr_fold, rs1_index, rd_index) in;
//        dispatch_stall, ras_push, ras_pop, alloc_valid/alloc_tag out;
//        resolve_valid/resolve_tag/resolve_mispredict in; ras_restore(+sp/count) out;
//        sp_shadow/count_shadow mirror the speculative RAS state; n_free counts free slots.
module ras_checkpoint_manager #(
    parameter int STACK_SIZE    = 16,
    parameter int N_CHECKPOINTS = 4,
    localparam int SPW = $clog2(STACK_SIZE),
    localparam int TW  = $clog2(N_CHECKPOINTS)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           dispatch_valid,
    input  logic           branch,
    input  logic           jump,
    input  logic           jalr,
    input  logic           jalr_fold,
    input  logic [4:0]     rs1_index,
    input  logic [4:0]     rd_index,
    output logic           dispatch_stall,
    output logic           ras_push,
    output logic           ras_pop,
    output logic           alloc_valid,
    output logic [TW-1:0]  alloc_tag,
    input  logic           resolve_valid,
    input  logic [TW-1:0]  resolve_tag,
    input  logic           resolve_mispredict,
    output logic           ras_restore,
    output logic [SPW-1:0] ras_restore_sp,
    output logic [SPW:0]   ras_restore_count,
    output logic [SPW-1:0] sp_shadow,
    output logic [SPW:0]   count_shadow,
    output logic [TW:0]    n_free
);
    localparam int TW1 = TW + 1;
    localparam int CW  = SPW + 1;
    localparam logic [TW:0]  N_SLOTS = TW1'(N_CHECKPOINTS);
    localparam logic [SPW:0] CNT_MAX = CW'(STACK_SIZE);

    typedef enum logic {RUN, RESTORE} state_t;
    state_t state, state_next;

    logic [TW-1:0]  head, tail, head_nx, res_off;
    logic [TW:0]    in_use;
    logic [N_CHECKPOINTS-1:0] done;
    logic [SPW-1:0] snap_sp  [N_CHECKPOINTS];
    logic [SPW:0]   snap_cnt [N_CHECKPOINTS];

    logic rd_link, rs1_link, push_req, pop_req, ckpt_req, accept;
    logic res_live, mp_hit, ok_hit, head_adv;
    logic [SPW-1:0] sp_upd;
    logic [SPW:0]   cnt_upd;

    // A tag is live when its distance from head falls inside the occupied window.
    assign res_off  = resolve_tag - head;
    assign res_live = ({1'b0, res_off} < in_use);
    assign mp_hit   = resolve_valid && resolve_mispredict && res_live;
    assign ok_hit   = resolve_valid && !resolve_mispredict && res_live;
    assign n_free   = N_SLOTS - in_use;
    assign ras_restore = (state == RESTORE);

    // Never retire the slot that is being rolled back in the same cycle.
    assign head_adv = (in_use != '0) && done[head] && !(mp_hit && (resolve_tag == head));
    assign head_nx  = head + TW'(head_adv);

    always_comb begin
        rd_link        = (rd_index == 5'd1) || (rd_index == 5'd5);
        rs1_link       = (rs1_index == 5'd1) || (rs1_index == 5'd5);
        push_req       = jump && rd_link;
        pop_req        = jump && jalr && rs1_link && (!rd_link || (rd_index != rs1_index));
        ckpt_req       = branch || (jump && jalr && !jalr_fold);
        dispatch_stall = dispatch_valid && ((state == RESTORE) ||
                         (resolve_valid && resolve_mispredict) ||
                         (ckpt_req && (n_free == '0)));
        accept         = dispatch_valid && !dispatch_stall;
        ras_push       = push_req && accept;
        ras_pop        = pop_req && accept;
        alloc_valid    = ckpt_req && accept;
        alloc_tag      = tail;
        sp_upd         = sp_shadow;
        cnt_upd        = count_shadow;
        // Mirror of the RAS pointer arithmetic; pointer wraps, count saturates.
        if (push_req && pop_req) begin
            if (count_shadow == '0) cnt_upd = CW'(1);
        end else if (pop_req) begin
            sp_upd = sp_shadow - SPW'(1);
            if (count_shadow != '0) cnt_upd = count_shadow - CW'(1);
        end else if (push_req) begin
            sp_upd = sp_shadow + SPW'(1);
            if (count_shadow != CNT_MAX) cnt_upd = count_shadow + CW'(1);
        end
    end

    always_comb begin
        state_next = RUN;
        if (mp_hit) state_next = RESTORE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head              <= '0;
            tail              <= '0;
            in_use            <= '0;
            done              <= '0;
            sp_shadow         <= '0;
            count_shadow      <= '0;
            ras_restore_sp    <= '0;
            ras_restore_count <= '0;
            for (int i = 0; i < N_CHECKPOINTS; i++) begin
                snap_sp[i]  <= '0;
                snap_cnt[i] <= '0;
            end
        end else begin
            head <= head_nx;
            if (ok_hit) done[resolve_tag] <= 1'b1;
            if (accept) begin
                sp_shadow    <= sp_upd;
                count_shadow <= cnt_upd;
            end
            if (alloc_valid) begin
                // Snapshot includes this instruction's own push/pop.
                snap_sp[tail]  <= sp_upd;
                snap_cnt[tail] <= cnt_upd;
                done[tail]     <= 1'b0;
            end
            if (mp_hit) begin
                tail              <= resolve_tag;
                in_use            <= {1'b0, resolve_tag - head_nx};
                sp_shadow         <= snap_sp[resolve_tag];
                count_shadow      <= snap_cnt[resolve_tag];
                ras_restore_sp    <= snap_sp[resolve_tag];
                ras_restore_count <= snap_cnt[resolve_tag];
            end else begin
                tail   <= tail + TW'(alloc_valid);
                in_use <= in_use + TW1'(alloc_valid) - TW1'(head_adv);
            end
        end
    end
endmodule

// File: tb/tb_ras_checkpoint_manager.sv
// Purpose: scoreboard bench for ras_checkpoint_manager with an independent behavioural model.
// Latency: combinational outputs checked before each edge; registered state popped from a queue after it.
// Backpressure: stall expectations come from the model's free-slot and restore tracking.
module tb_ras_checkpoint_manager;
    localparam int NC = 4;
    localparam int SS = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       dispatch_valid, branch, jump, jalr, jalr_fold;
    logic [4:0] rs1_index, rd_index;
    logic       dispatch_stall, ras_push, ras_pop, alloc_valid;
    logic [1:0] alloc_tag;
    logic       resolve_valid, resolve_mispredict;
    logic [1:0] resolve_tag;
    logic       ras_restore;
    logic [3:0] ras_restore_sp, sp_shadow;
    logic [4:0] ras_restore_count, count_shadow;
    logic [2:0] n_free;

    ras_checkpoint_manager #(.STACK_SIZE(SS), .N_CHECKPOINTS(NC)) dut (
        .clk(clk), .reset(reset),
        .dispatch_valid(dispatch_valid), .branch(branch), .jump(jump), .jalr(jalr),
        .jalr_fold(jalr_fold), .rs1_index(rs1_index), .rd_index(rd_index),
        .dispatch_stall(dispatch_stall), .ras_push(ras_push), .ras_pop(ras_pop),
        .alloc_valid(alloc_valid), .alloc_tag(alloc_tag),
        .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
        .resolve_mispredict(resolve_mispredict),
        .ras_restore(ras_restore), .ras_restore_sp(ras_restore_sp),
        .ras_restore_count(ras_restore_count),
        .sp_shadow(sp_shadow), .count_shadow(count_shadow), .n_free(n_free)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sp;
        int cnt;
        int nfree;
        int rst;
        int rsp;
        int rcnt;
    } exp_t;
    exp_t sb_q[$];

    int errors = 0;
    int checks = 0;

    // model state
    int m_head, m_tail, m_inuse, m_sp, m_cnt, m_restore, m_rsp, m_rcnt;
    int m_done [NC];
    int m_ssp  [NC];
    int m_scnt [NC];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_head = 0; m_tail = 0; m_inuse = 0; m_sp = 0; m_cnt = 0;
        m_restore = 0; m_rsp = 0; m_rcnt = 0;
        for (int i = 0; i < NC; i++) begin
            m_done[i] = 0; m_ssp[i] = 0; m_scnt[i] = 0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".sp"},     sp_shadow, 0);
        check({tag, ".cnt"},    count_shadow, 0);
        check({tag, ".nfree"},  n_free, NC);
        check({tag, ".rst"},    ras_restore, 0);
        check({tag, ".rsp"},    ras_restore_sp, 0);
        check({tag, ".rcnt"},   ras_restore_count, 0);
        check({tag, ".stall"},  dispatch_stall, 0);
        check({tag, ".alloc"},  alloc_valid, 0);
    endtask

    task automatic idle_inputs();
        dispatch_valid = 0; branch = 0; jump = 0; jalr = 0; jalr_fold = 0;
        rs1_index = 0; rd_index = 0;
        resolve_valid = 0; resolve_tag = 0; resolve_mispredict = 0;
    endtask

    // Asynchronous reset: checked #1 after assertion, before any clock edge.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        idle_inputs();
        #1;
        check_reset_outputs(tag);
        model_reset();
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input string tag, input logic dv, input logic br, input logic jp,
                        input logic jr, input logic fold, input int rs1, input int rd,
                        input logic rv, input int rt, input logic rm);
        bit rdl, rsl, push, pop, ck, stall, acc, live, mp, ok, adv;
        int nsp, ncnt, off;
        exp_t e, g;
        @(negedge clk);
        dispatch_valid = dv; branch = br; jump = jp; jalr = jr; jalr_fold = fold;
        rs1_index = 5'(rs1); rd_index = 5'(rd);
        resolve_valid = rv; resolve_tag = 2'(rt); resolve_mispredict = rm;
        #1;
        rdl   = (rd == 1) || (rd == 5);
        rsl   = (rs1 == 1) || (rs1 == 5);
        push  = jp && rdl;
        pop   = jp && jr && rsl && (!rdl || rd != rs1);
        ck    = br || (jp && jr && !fold);
        stall = dv && (m_restore != 0 || (rv && rm) || (ck && m_inuse == NC));
        acc   = dv && !stall;
        check({tag, ".stall"}, dispatch_stall, stall);
        check({tag, ".push"},  ras_push, push && acc);
        check({tag, ".pop"},   ras_pop, pop && acc);
        check({tag, ".alloc"}, alloc_valid, ck && acc);
        if (ck && acc) check({tag, ".tag"}, alloc_tag, m_tail);

        nsp = m_sp; ncnt = m_cnt;
        if (push && pop) begin
            if (m_cnt == 0) ncnt = 1;
        end else if (pop) begin
            nsp = (m_sp + SS - 1) % SS;
            ncnt = (m_cnt > 0) ? m_cnt - 1 : 0;
        end else if (push) begin
            nsp = (m_sp + 1) % SS;
            ncnt = (m_cnt < SS) ? m_cnt + 1 : SS;
        end

        off  = (rt - m_head + NC) % NC;
        live = rv && (off < m_inuse);
        mp   = live && rm;
        ok   = live && !rm;
        adv  = (m_inuse > 0) && (m_done[m_head] != 0) && !(mp && rt == m_head);

        if (ok) m_done[rt] = 1;
        if (acc) begin m_sp = nsp; m_cnt = ncnt; end
        if (ck && acc) begin
            m_ssp[m_tail] = nsp; m_scnt[m_tail] = ncnt; m_done[m_tail] = 0;
            m_tail = (m_tail + 1) % NC;
            m_inuse++;
        end
        if (adv) begin
            m_head = (m_head + 1) % NC;
            m_inuse--;
        end
        m_restore = mp;
        if (mp) begin
            m_tail  = rt;
            m_inuse = (rt - m_head + NC) % NC;
            m_sp    = m_ssp[rt]; m_cnt = m_scnt[rt];
            m_rsp   = m_ssp[rt]; m_rcnt = m_scnt[rt];
        end
        e.sp = m_sp; e.cnt = m_cnt; e.nfree = NC - m_inuse;
        e.rst = m_restore; e.rsp = m_rsp; e.rcnt = m_rcnt;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 0, 1);
        end else begin
            g = sb_q.pop_front();
            check({tag, ".sp"},    sp_shadow, g.sp);
            check({tag, ".cnt"},   count_shadow, g.cnt);
            check({tag, ".nfree"}, n_free, g.nfree);
            check({tag, ".rst"},   ras_restore, g.rst);
            check({tag, ".rsp"},   ras_restore_sp, g.rsp);
            check({tag, ".rcnt"},  ras_restore_count, g.rcnt);
        end
    endtask

    task automatic do_branch(input string tag);
        step(tag, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_jal_link(input string tag);
        step(tag, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic idle_cycle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        reset = 1'b0;
        #2;
        do_reset("rst0");

        // JAL x1: push only, no checkpoint
        do_jal_link("jal");

        // JALR rd=x1 rs1=x5 at count 0: push+pop, checkpoint tag 0 (snap sp0 cnt1)
        do_reset("rst1");
        step("jalr_pp", 1, 0, 1, 1, 0, 5, 1, 0, 0, 0);
        idle_cycle("jalr_pp_idle");

        // fill all four checkpoints; tag1 snapshot sp=3 cnt=3
        do_reset("rst2");
        do_jal_link("p1");
        do_jal_link("p2");
        do_branch("b0");
        do_jal_link("p3");
        do_branch("b1");
        do_branch("b2");
        do_branch("b3");
        do_branch("b4_full");
        do_jal_link("jal_full");
        // mispredict on tag 1 with a same-cycle dispatch
        step("mp1", 1, 0, 1, 0, 0, 0, 1, 1, 1, 1);
        do_jal_link("in_restore");
        // mispredict on a freed tag is ignored (dispatch still stalls)
        step("mp_free", 1, 1, 0, 0, 0, 0, 0, 1, 2, 1);
        step("res0", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle_cycle("drain0");
        idle_cycle("drain1");

        // pop at count 0 wraps sp, count saturates; then resolve out of order
        do_reset("rst3");
        step("pop_wrap", 1, 0, 1, 1, 1, 1, 0, 0, 0, 0);
        do_branch("c0");
        do_branch("c1");
        do_branch("c2");
        do_branch("c3");
        step("res_t1", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step("res_t0", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle_cycle("adv0");
        idle_cycle("adv1");
        idle_cycle("adv2");
        // allocation reuses freed slots while tags 2,3 stay live
        do_branch("c4");
        do_branch("c5");
        do_branch("c6_full");

        // reset asserted during RESTORE takes effect without a clock edge
        do_reset("rst4");
        do_jal_link("q1");
        do_branch("d0");
        step("mp0", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        #2;
        do_reset("rst_in_restore");
        idle_cycle("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule

// File: doc/ras_checkpoint_manager.md
Name: ras_checkpoint_manager

Overview:
- Controller that sequences the return address stack (RAS) from the dispatch stage.
- Decodes RAS push/pop hints and allocates up to N_CHECKPOINTS in-flight speculation checkpoints, replacing the RAS's single checkpoint register.
- Each checkpoint holds a snapshot of the stack pointer and entry count. On branch resolution it frees the checkpoint, or drives a restore of the RAS with that snapshot.

Parameters:
- STACK_SIZE, 16, depth of the controlled RAS (power of two).
- N_CHECKPOINTS, 4, number of checkpoint slots (power of two, at least 2).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- dispatch_valid  in  1  an instruction is presented at dispatch.
- branch  in  1  instruction is a conditional branch.
- jump  in  1  instruction is JAL/JALR.
- jalr  in  1  0 = JAL, 1 = JALR.
- jalr_fold  in  1  JALR folded with a U-type instruction, so it is deterministic.
- rs1_index  in  5  source register index.
- rd_index  in  5  destination register index.
- dispatch_stall  out  1  instruction not accepted this cycle.
- ras_push  out  1  push command to the RAS.
- ras_pop  out  1  pop command to the RAS.
- alloc_valid  out  1  a checkpoint was allocated this cycle.
- alloc_tag  out  log2(N_CHECKPOINTS)  tag of the allocated checkpoint.
- resolve_valid  in  1  a checkpointed instruction resolved.
- resolve_tag  in  log2(N_CHECKPOINTS)  tag being resolved.
- resolve_mispredict  in  1  resolution was a misprediction.
- ras_restore  out  1  RAS must load the restore values this cycle.
- ras_restore_sp  out  log2(STACK_SIZE)  restored stack pointer.
- ras_restore_count  out  log2(STACK_SIZE)+1  restored entry count.
- sp_shadow  out  log2(STACK_SIZE)  speculative stack pointer mirror.
- count_shadow  out  log2(STACK_SIZE)+1  speculative entry count mirror.
- n_free  out  log2(N_CHECKPOINTS)+1  number of free checkpoint slots.

Behaviour:
- Reset (asynchronous, active-high), also mid-operation:
  - All slots free; head = tail = 0; in_use = 0; n_free = N_CHECKPOINTS.
  - sp_shadow = 0; count_shadow = 0; state = RUN.
  - ras_restore = 0; restore values = 0; all done bits = 0.
- Hint decode (combinational), where link = rd or rs1 index equal to 1 or 5:
  - push_req = jump && rd is link.
  - pop_req = jump && jalr && rs1 is link && (rd is not link || rd != rs1).
  - ckpt_req = branch || (jump && jalr && !jalr_fold).
- Stall: dispatch_stall = dispatch_valid && (state == RESTORE || (resolve_valid && resolve_mispredict) || (ckpt_req && n_free == 0)).
- Accepted dispatch = dispatch_valid && !dispatch_stall.
  - ras_push = push_req && accepted; ras_pop = pop_req && accepted. Both are combinational, zero latency.
  - Without acceptance, ras_push, ras_pop and alloc_valid are 0.
- Shadow update on accept, mirroring the RAS; sp wraps modulo STACK_SIZE:
  - push and pop: sp unchanged; count + 1 only if count == 0.
  - pop only: sp - 1; count saturates at 0.
  - push only: sp + 1; count saturates at STACK_SIZE.
- Checkpoint allocation on accept with ckpt_req:
  - alloc_valid = 1 and alloc_tag = tail, combinationally in the same cycle.
  - The slot stores the post-update shadow, i.e. after this instruction's own push/pop; the checkpointing instruction is never squashed.
  - On the next edge: tail + 1 mod N, in_use + 1, done bit cleared.
- Correct resolution (resolve_valid && !resolve_mispredict):
  - Sets the done bit of resolve_tag if that slot is in use; otherwise ignored.
  - Each cycle head advances by at most one slot, only when in_use > 0 and slot[head] is done; in_use decrements.
  - n_free = N_CHECKPOINTS - in_use, registered.
- Mispredict (resolve_valid && resolve_mispredict on an in-use tag t):
  - Next edge: state = RESTORE; ras_restore = 1; ras_restore_sp/count = snapshot[t].
  - sp_shadow/count_shadow are loaded with snapshot[t].
  - tail = t and in_use = (t - head) mod N; slot t and all younger slots are freed.
  - Same-cycle dispatch is dropped.
  - A mispredict on a free tag is ignored.
  - A same-cycle head advance is applied before in_use is recomputed.
- RESTORE state: lasts exactly one cycle with ras_restore = 1 and dispatch stalled, then returns to RUN. Resolutions arriving during RESTORE are processed normally.
- Only one resolution per cycle.

Test Plan:
- Reset, then an accepted JAL with rd = x1: ras_push = 1, ras_pop = 0, no alloc; next cycle sp_shadow = 1, count_shadow = 1.
- JALR rd = x1, rs1 = x5, jalr_fold = 0, with count 0: push = pop = 1, alloc_tag = 0; snapshot sp = 0, count = 1; n_free = 3 next cycle.
- Four branches accepted back to back: tags 0, 1, 2, 3; a fifth branch gives dispatch_stall = 1 and alloc_valid = 0, while a non-checkpoint instruction in the same state is still accepted.
- Resolve tag 1 correct, then tag 0 correct: head reaches 2 after two cycles; n_free goes 0 → 1 → 2.
- With checkpoints 0..3 live, mispredict tag 1 (snapshot sp = 3, count = 3) plus a same-cycle dispatch:
  - Dispatch stalls.
  - Next cycle ras_restore = 1, sp = 3, count = 3, tail = 1, n_free updated.
  - Dispatch is stalled one cycle more.
- Assert reset during RESTORE: all outputs return to their reset values immediately, with no clock edge needed.
